// File: rtl/ram_streamer_pkg.sv
// Shared types and constants for the ram_streamer playback engine.
package ram_streamer_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_LOOP    = 1'b1;

endpackage

// File: rtl/ram_sp_array.sv
// Word array with one synchronous write port and one asynchronous read port.
module ram_sp_array #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 32
) (
    input  logic                       clock,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [DATA_W-1:0]          rd_data_c
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_in_range_c;
    logic              rd_in_range_c;

    // Addresses past the last word exist only when DEPTH is not a power of two.
    assign wr_in_range_c = ({1'b0, wr_addr} < (ADDR_W + 1)'(DEPTH));
    assign rd_in_range_c = ({1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH));

    always_ff @(posedge clock) begin
        if (wr_en && wr_in_range_c) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = rd_in_range_c ? mem[rd_addr] : '0;

endmodule

// File: rtl/ram_streamer.sv
// Memory with a host write port and a valid/ready playback engine over a
// programmable, wrapping window; one-shot or looped, with stall and abort.
module ram_streamer
    import ram_streamer_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              loop_mode,
    input  logic              abort,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] ram_out,
    output logic              out_last,
    output logic              busy
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              loop_q, loop_d;
    logic [DATA_W-1:0] ram_out_d;
    logic              valid_d, last_d, busy_d;

    logic [ADDR_W-1:0] rd_addr_c;
    logic [DATA_W-1:0] rd_data_c;
    logic              start_ok_c;
    logic              xfer_c;

    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        if (32'(p) >= DEPTH - 1) begin
            return '0;
        end
        return p + ADDR_W'(1);
    endfunction

    ram_sp_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clock     (clock),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr_c),
        .rd_data_c (rd_data_c)
    );

    assign start_ok_c = start && (length != '0) && (32'(length) <= DEPTH);
    assign xfer_c     = out_valid && out_ready;

    // Single read port: window base when starting or restarting a pass, else the running pointer.
    always_comb begin
        rd_addr_c = ptr_q;
        if (state_q == ST_IDLE) begin
            rd_addr_c = base_addr;
        end else if (rem_q == '0) begin
            rd_addr_c = base_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        base_d    = base_q;
        len_d     = len_q;
        rem_d     = rem_q;
        loop_d    = loop_q;
        ram_out_d = ram_out;
        valid_d   = out_valid;
        last_d    = out_last;

        case (state_q)
            ST_IDLE: begin
                if (start_ok_c) begin
                    base_d    = base_addr;
                    len_d     = length;
                    loop_d    = loop_mode;
                    ram_out_d = rd_data_c;
                    valid_d   = 1'b1;
                    last_d    = (length == LEN_W'(1));
                    ptr_d     = ptr_inc(base_addr);
                    rem_d     = length - LEN_W'(1);
                    state_d   = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (xfer_c) begin
                    if (rem_q != '0) begin
                        ram_out_d = rd_data_c;
                        ptr_d     = ptr_inc(ptr_q);
                        rem_d     = rem_q - LEN_W'(1);
                        last_d    = (rem_q == LEN_W'(1));
                    end else if (loop_q == MODE_LOOP) begin
                        ram_out_d = rd_data_c;
                        ptr_d     = ptr_inc(base_q);
                        rem_d     = len_q - LEN_W'(1);
                        last_d    = (len_q == LEN_W'(1));
                    end else begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                // Abort wins over a loop restart; a coincident transfer is still consumed.
                if (abort) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_STREAM);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            base_q    <= '0;
            len_q     <= '0;
            rem_q     <= '0;
            loop_q    <= MODE_ONESHOT;
            ram_out   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            base_q    <= base_d;
            len_q     <= len_d;
            rem_q     <= rem_d;
            loop_q    <= loop_d;
            ram_out   <= ram_out_d;
            out_valid <= valid_d;
            out_last  <= last_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_ram_streamer.sv
// Randomized self-checking bench for ram_streamer against a window/array reference model.
module tb_ram_streamer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic              loop_mode;
    logic              abort;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] ram_out;
    logic              out_last;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DATA_W-1:0] mm [DEPTH];

    ram_streamer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .loop_mode (loop_mode),
        .abort     (abort),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .ram_out   (ram_out),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Plays one window: total words consumed, then (loop only) abort.
    // rmode 0 = ready high, 1 = random ready, 2 = stall 3 cycles on second word.
    task automatic stream(input int base, input int len, input bit lp, input int total,
                          input int rmode, input bit rnd_wr,
                          input int wr_at, input int wr_a, input int wr_d);
        int idx = 0;
        int stall = 0;
        int cyc = 0;
        bit r;
        logic [DATA_W-1:0] exp_w;
        wr_en = 1'b0;
        start = 1'b1;
        base_addr = ADDR_W'(base);
        length = (ADDR_W + 1)'(len);
        loop_mode = lp;
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        exp_w = mm[base % DEPTH];
        while (idx < total && cyc < 4000) begin
            chk("valid", 32'(out_valid), 1);
            chk("data", 32'(ram_out), 32'(exp_w));
            chk("last", 32'(out_last), 32'((idx % len) == len - 1));
            case (rmode)
                0: r = 1'b1;
                1: r = ($urandom_range(0, 2) != 0);
                default: begin
                    r = !(idx == 1 && stall < 3);
                    if (!r) stall++;
                end
            endcase
            out_ready = r;
            // Starts while streaming must be ignored.
            start = ($urandom_range(0, 7) == 0);
            base_addr = ADDR_W'($urandom);
            length = (ADDR_W + 1)'($urandom_range(1, DEPTH));
            wr_en = 1'b0;
            if (rnd_wr && $urandom_range(0, 2) == 0) begin
                wr_en = 1'b1;
                wr_addr = ADDR_W'($urandom);
                wr_data = DATA_W'($urandom);
            end
            if (idx == wr_at && r) begin
                wr_en = 1'b1;
                wr_addr = ADDR_W'(wr_a);
                wr_data = DATA_W'(wr_d);
            end
            if (r) begin
                idx++;
                exp_w = mm[(base + (idx % len)) % DEPTH];
            end
            if (wr_en) mm[wr_addr] = wr_data;
            tick();
            cyc++;
        end
        start = 1'b0;
        wr_en = 1'b0;
        if (cyc >= 4000) chk("stream_timeout", 32'(cyc), 0);
        if (rmode == 0 && !lp) chk("throughput_cycles", 32'(cyc), 32'(len));
        if (lp) begin
            chk("loop_valid_before_abort", 32'(out_valid), 1);
            abort = 1'b1;
            out_ready = 1'b1;
            tick();
            abort = 1'b0;
        end
        chk("end_valid", 32'(out_valid), 0);
        chk("end_last", 32'(out_last), 0);
        chk("end_busy", 32'(busy), 0);
        out_ready = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        loop_mode = 1'b0;
        abort = 1'b0;
        out_ready = 1'b1;
        #2;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(ram_out), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_busy", 32'(busy), 0);
        #10;
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1;
            wr_addr = ADDR_W'(i);
            wr_data = DATA_W'(i + 8'h10);
            mm[i] = DATA_W'(i + 8'h10);
            tick();
        end
        wr_en = 1'b0;

        stream(4, 3, 1'b0, 3, 0, 1'b0, -1, 0, 0);
        stream(30, 4, 1'b0, 4, 0, 1'b0, -1, 0, 0);
        stream(4, 3, 1'b0, 3, 2, 1'b0, -1, 0, 0);
        stream(0, 2, 1'b1, 7, 0, 1'b0, -1, 0, 0);
        // Write lands on the address fetched at the same edge: old value first, new on next pass.
        stream(5, 3, 1'b1, 6, 0, 1'b0, 0, 6, 8'hAA);
        chk("collision_mem_model", 32'(mm[6]), 32'h0AA);
        stream(0, 32, 1'b0, 32, 0, 1'b0, -1, 0, 0);
        stream(31, 1, 1'b0, 1, 0, 1'b0, -1, 0, 0);

        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle_busy", 32'(busy), 0);

        for (int t = 0; t < 25; t++) begin
            int b = $urandom_range(0, DEPTH - 1);
            int l = $urandom_range(1, DEPTH);
            bit lp = 1'($urandom_range(0, 1));
            int tot = lp ? $urandom_range(1, 3 * l) : l;
            stream(b, l, lp, tot, $urandom_range(0, 1), 1'b1, -1, 0, 0);
        end

        // Asynchronous reset in the middle of a pass.
        start = 1'b1;
        base_addr = '0;
        length = 6'd20;
        loop_mode = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_data", 32'(ram_out), 0);
        chk("midrst_last", 32'(out_last), 0);
        chk("midrst_busy", 32'(busy), 0);
        #4;
        reset_n = 1'b1;
        tick();

        start = 1'b1;
        length = '0;
        base_addr = 5'd3;
        tick();
        start = 1'b0;
        chk("len0_busy", 32'(busy), 0);
        chk("len0_valid", 32'(out_valid), 0);
        start = 1'b1;
        length = 6'd33;
        tick();
        start = 1'b0;
        chk("len33_busy", 32'(busy), 0);
        tick();
        chk("len33_busy_later", 32'(busy), 0);

        stream(2, 5, 1'b0, 5, 1, 1'b0, -1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_streamer.md
# ram_streamer

Parametrised successor to the 8-bit free-running `ram`: a single-clock memory array with a host write port and a streaming read engine that plays back a programmable window of words over a valid/ready output. Supports one-shot and looped playback, back-pressure, and abort. Sits between the loader/testbench side that fills memory and the downstream consumer that previously sampled `ram_out` every clock.

## Interface
- DATA_W, 8, word width
- DEPTH, 32, number of words (any value ≥ 2, need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width (derived; do not override)
- clock  in  1  sole clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address; values ≥ DEPTH are dropped
- wr_data  in  DATA_W  write data
- start  in  1  begin playback; sampled only in IDLE
- base_addr  in  ADDR_W  first word of window, captured with start
- length  in  ADDR_W+1  words per pass, 1..DEPTH, captured with start
- loop_mode  in  1  0 = one-shot, 1 = repeat until abort; captured with start
- abort  in  1  stop playback
- out_ready  in  1  consumer accepts ram_out
- out_valid  out  1  ram_out holds a valid word
- ram_out  out  DATA_W  streamed data
- out_last  out  1  final word of current pass
- busy  out  1  engine not in IDLE

## Operation
- States: IDLE, STREAM.
- IDLE: start=1 with 1 ≤ length ≤ DEPTH → capture base_addr, length, loop_mode; load ram_out ← mem[base_addr], out_valid←1, out_last←(length==1); next ptr=base+1, remaining=length−1; go STREAM. start with length=0 or length>DEPTH: ignored, stay IDLE.
- STREAM, transfer (out_valid && out_ready): if remaining>0 → ram_out←mem[ptr], ptr advances, remaining−1, out_last←(remaining==1). If remaining==0: loop_mode=1 → reload from base (pass restarts, no bubble); loop_mode=0 → out_valid←0, out_last←0, go IDLE.
- STREAM, no transfer: ram_out, out_valid, out_last held stable (no change while stalled).
- Pointer arithmetic: ptr = (ptr+1) mod DEPTH; window wraps past DEPTH−1 to 0.
- abort=1 in STREAM: next edge out_valid←0, out_last←0, go IDLE; a coincident transfer still completes. abort has priority over loop restart. abort in IDLE: no effect.
- start in STREAM: ignored.
- Writes: accepted every cycle in any state. Same-edge write and fetch of the same address → fetched word is the old contents (read-before-write).
- Memory contents are not reset; only control state and outputs are.

## Timing
- Reset (async assert): out_valid=0, out_last=0, busy=0, ram_out=0, state=IDLE, regardless of clock; mid-stream reset discards the pass, memory preserved.
- start sampled at edge k → out_valid=1 with first word after edge k; busy=1 after edge k.
- Throughput 1 word/cycle while out_ready=1; playback of length N with ready held high takes N cycles of out_valid.
- Write at edge k is visible to a fetch at edge k+1 or later.
- busy drops after the edge that accepts the last one-shot word or after the abort edge.

## Structure
- Package ram_streamer_pkg: state enum (IDLE, STREAM), mode constants MODE_ONESHOT=0, MODE_LOOP=1.
- Sub-module ram_sp_array (DATA_W, DEPTH): one write port, one asynchronous read port feeding the engine's output register; engine FSM and counters in ram_streamer.

## Test plan
- Preload mem[i]=i+0x10 (DEPTH=32); start base=4, length=3, one-shot, ready=1 → ram_out 0x14,0x15,0x16 on consecutive cycles, out_last with 0x16, then out_valid=0, busy=0.
- Wrap: base=30, length=4 → 0x2E,0x2F,0x10,0x11.
- Back-pressure: same as first, out_ready low 3 cycles on second word → 0x15 held stable with out_valid=1, no word lost or duplicated.
- Loop: base=0, length=2, loop_mode=1 → 0x10,0x11,0x10,0x11… out_last on every 0x11; abort → out_valid=0 next edge, busy=0.
- Collision: while streaming, write 0xAA to the address being fetched that edge → old value streamed; next pass (loop) shows 0xAA.
- Reset mid-stream and length=0 start: reset_n low asynchronously → all outputs 0 before next edge; after release, start with length=0 → busy stays 0.
